// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control path: opcodes, ALUOp encodings
// and the bundle of datapath control strobes.
package mips_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               regDst;
        logic               jump;
        logic               branch;
        logic               memRead;
        logic               memtoReg;
        logic [ALUOP_W-1:0] aluOp;
        logic               memWrite;
        logic               aluSrc;
        logic               regWrite;
    } ctrl_t;

    // Every strobe inactive and aluOp = add; also the value for unsupported opcodes.
    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/main_control_if.sv
// Opcode in, control strobes out; master drives the opcode, slave is the decoder.
interface main_control_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                regDst;
    logic                jump;
    logic                branch;
    logic                memRead;
    logic                memtoReg;
    logic [ALUOP_W-1:0]  aluOp;
    logic                memWrite;
    logic                aluSrc;
    logic                regWrite;
    logic                illegal;

    modport master (
        output opcode,
        input  regDst, jump, branch, memRead, memtoReg, aluOp,
        input  memWrite, aluSrc, regWrite, illegal
    );

    modport slave (
        input  opcode,
        output regDst, jump, branch, memRead, memtoReg, aluOp,
        output memWrite, aluSrc, regWrite, illegal
    );

endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode-to-strobe mapping; unknown opcodes yield no
// strobes at all plus the illegal flag.
module control_decode
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regDst   = 1'b1;
                ctrl.aluOp    = ALUOP_FUNCT;
                ctrl.regWrite = 1'b1;
            end
            OP_LW: begin
                ctrl.memRead  = 1'b1;
                ctrl.memtoReg = 1'b1;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_SW: begin
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.aluOp    = ALUOP_SUB;
            end
            OP_J: begin
                ctrl.jump     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/main_control.sv
// Main control decoder: decodes the opcode and registers the strobes, giving
// one cycle of latency; reset clears every output immediately.
module main_control
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    main_control_if.slave  bus
);

    ctrl_t next_ctrl;
    ctrl_t ctrl_q;
    logic  next_illegal;
    logic  illegal_q;

    control_decode u_decode (
        .opcode  (bus.opcode),
        .ctrl    (next_ctrl),
        .illegal (next_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= CTRL_NONE;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= next_ctrl;
            illegal_q <= next_illegal;
        end
    end

    assign bus.regDst   = ctrl_q.regDst;
    assign bus.jump     = ctrl_q.jump;
    assign bus.branch   = ctrl_q.branch;
    assign bus.memRead  = ctrl_q.memRead;
    assign bus.memtoReg = ctrl_q.memtoReg;
    assign bus.aluOp    = ctrl_q.aluOp;
    assign bus.memWrite = ctrl_q.memWrite;
    assign bus.aluSrc   = ctrl_q.aluSrc;
    assign bus.regWrite = ctrl_q.regWrite;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_main_control.sv
// Directed self-checking bench for main_control; outputs are compared as an
// 11-bit vector {regDst,jump,branch,memRead,memtoReg,aluOp,memWrite,aluSrc,regWrite,illegal}.
module tb_main_control;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;

    main_control_if bus ();

    main_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written expectations, bit order as in the header.
    localparam logic [10:0] EXP_ZERO  = 11'b0_0_0_0_0_00_0_0_0_0;
    localparam logic [10:0] EXP_RTYPE = 11'b1_0_0_0_0_10_0_0_1_0;
    localparam logic [10:0] EXP_LW    = 11'b0_0_0_1_1_00_0_1_1_0;
    localparam logic [10:0] EXP_SW    = 11'b0_0_0_0_0_00_1_1_0_0;
    localparam logic [10:0] EXP_BEQ   = 11'b0_0_1_0_0_01_0_0_0_0;
    localparam logic [10:0] EXP_J     = 11'b0_1_0_0_0_00_0_0_0_0;
    localparam logic [10:0] EXP_ADDI  = 11'b0_0_0_0_0_00_0_1_1_0;
    localparam logic [10:0] EXP_ILL   = 11'b0_0_0_0_0_00_0_0_0_1;

    function automatic logic [10:0] observed();
        return {bus.regDst, bus.jump, bus.branch, bus.memRead, bus.memtoReg,
                bus.aluOp, bus.memWrite, bus.aluSrc, bus.regWrite, bus.illegal};
    endfunction

    function automatic logic [10:0] expectedFor(input logic [5:0] op);
        case (op)
            6'b000000: return EXP_RTYPE;
            6'b100011: return EXP_LW;
            6'b101011: return EXP_SW;
            6'b000100: return EXP_BEQ;
            6'b000010: return EXP_J;
            6'b001000: return EXP_ADDI;
            default:   return EXP_ILL;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] actual,
                               input logic [10:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Drive an opcode between edges, then sample 1 ns after the next rising edge.
    task automatic applyStimulus(input logic [5:0] op);
        @(negedge clk);
        bus.opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        bus.opcode = 6'b000000;

        #1;
        checkOutput("reset_no_edge", observed(), EXP_ZERO);
        @(posedge clk);
        #1;
        checkOutput("reset_held_over_edge", observed(), EXP_ZERO);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_edge_rtype", observed(), EXP_RTYPE);

        applyStimulus(6'b100011);
        checkOutput("lw", observed(), EXP_LW);
        applyStimulus(6'b101011);
        checkOutput("sw_after_lw", observed(), EXP_SW);
        applyStimulus(6'b000100);
        checkOutput("beq", observed(), EXP_BEQ);
        applyStimulus(6'b000010);
        checkOutput("j_after_beq", observed(), EXP_J);
        applyStimulus(6'b001000);
        checkOutput("addi", observed(), EXP_ADDI);
        applyStimulus(6'b111111);
        checkOutput("illegal_111111", observed(), EXP_ILL);
        applyStimulus(6'b000101);
        checkOutput("illegal_000101", observed(), EXP_ILL);
        applyStimulus(6'b000000);
        checkOutput("rtype_clears_illegal", observed(), EXP_RTYPE);

        // Reset pulse between edges while lw is being decoded.
        applyStimulus(6'b100011);
        checkOutput("lw_before_reset", observed(), EXP_LW);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_midcycle", observed(), EXP_ZERO);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("still_clear_after_release", observed(), EXP_ZERO);
        @(posedge clk);
        #1;
        checkOutput("post_reset_edge_lw", observed(), EXP_LW);

        // Every opcode, back to back, with the invariants checked each cycle.
        for (int i = 0; i < 64; i++) begin
            logic [5:0]  op;
            logic [10:0] obs;
            op = 6'(i);
            applyStimulus(op);
            obs = observed();
            checkOutput($sformatf("sweep_op_%02h", op), obs, expectedFor(op));
            checkOutput($sformatf("inv_rd_wr_%02h", op), {10'b0, bus.memRead & bus.memWrite}, EXP_ZERO);
            checkOutput($sformatf("inv_regwr_memwr_%02h", op), {10'b0, bus.regWrite & bus.memWrite}, EXP_ZERO);
            checkOutput($sformatf("inv_jump_branch_%02h", op), {10'b0, bus.jump & bus.branch}, EXP_ZERO);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/main_control.md
Name: main_control

Overview:
- Main control decoder for the single-cycle MIPS datapath.
- Decodes the 6-bit instruction opcode into the datapath control strobes: register-destination select, jump, branch, memory read/write, write-back select, ALU operation class, ALU source select and register-file write enable.
- Outputs are registered, so the block sits between instruction fetch/decode and the datapath muxes.
- Also flags unsupported opcodes.

Parameters:
- None. Opcode width is fixed at 6 and ALUOp width is fixed at 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all outputs
- opcode  input  6  instruction bits [31:26]
- regDst  output  1  1 = write register is rd, 0 = rt
- jump  output  1  1 = PC takes the jump target
- branch  output  1  1 = conditional branch (ANDed with ALU zero in the datapath)
- memRead  output  1  data memory read enable
- memtoReg  output  1  1 = write-back data comes from memory, 0 = from ALU
- aluOp  output  2  00 = add, 01 = subtract (compare), 10 = use funct field, 11 = reserved
- memWrite  output  1  data memory write enable
- aluSrc  output  1  1 = ALU operand B is the sign-extended immediate, 0 = rt
- regWrite  output  1  register-file write enable
- illegal  output  1  1 = opcode not in the supported set

Behaviour:
- Reset is asynchronous and active-high. While reset = 1, every output is 0, including aluOp = 00 and illegal = 0. Deassertion takes effect at the next rising clk edge.
- Decode is purely combinational from opcode. Its result is captured into output registers on each rising clk edge.
- Latency is 1 cycle: outputs reflect the opcode sampled at the previous edge. There are no stall or enable inputs; every edge samples.
- Decode table (signal order: regDst, jump, branch, memRead, memtoReg, aluOp, memWrite, aluSrc, regWrite, illegal):
  - 000000 R-type: 1, 0, 0, 0, 0, 10, 0, 0, 1, 0
  - 100011 lw: 0, 0, 0, 1, 1, 00, 0, 1, 1, 0
  - 101011 sw: 0, 0, 0, 0, 0, 00, 1, 1, 0, 0
  - 000100 beq: 0, 0, 1, 0, 0, 01, 0, 0, 0, 0
  - 000010 j: 0, 1, 0, 0, 0, 00, 0, 0, 0, 0
  - 001000 addi: 0, 0, 0, 0, 0, 00, 0, 1, 1, 0
  - any other opcode (e.g. 111111, 000011, 000101): all strobes 0, aluOp 00, illegal 1
- Don't-care fields are driven to 0. No X is ever propagated.
- Invariants, holding in every cycle:
  - memRead and memWrite are never both 1.
  - regWrite = 1 implies memWrite = 0.
  - At most one of jump and branch is 1.
- Opcode changing every cycle: each cycle's registered outputs correspond exactly to the prior cycle's opcode. There is no hold-over between cycles.
- Reset asserted mid-stream: outputs clear immediately, without waiting for a clock edge. The first post-reset edge loads the decode of the current opcode.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp encodings: ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10
  - a packed struct ctrl_t bundling the nine strobes
- One sub-module, control_decode, does the combinational opcode-to-ctrl_t mapping plus illegal. main_control wraps it with the async-reset output register.

Test Plan:
- Reset: assert reset with opcode = 000000 -> all outputs 0 without any clock edge. Release reset, one edge later -> regDst = 1, aluOp = 10, regWrite = 1.
- lw then sw on consecutive cycles: opcode = 100011 then 101011 -> first memRead = 1, memtoReg = 1, aluSrc = 1, regWrite = 1; next cycle memWrite = 1, aluSrc = 1, regWrite = 0, memRead = 0.
- beq then j: opcode = 000100 then 000010 -> branch = 1 with aluOp = 01; then jump = 1 with branch = 0 and all other strobes 0.
- addi: opcode = 001000 -> aluSrc = 1, regWrite = 1, regDst = 0, aluOp = 00, illegal = 0.
- Illegal opcodes: opcode = 111111, then 000101 -> illegal = 1, all strobes 0, aluOp = 00. Opcode = 000000 on the following edge -> illegal = 0.
- Async reset mid-stream: reset asserted between edges while opcode = 100011 is being decoded -> outputs clear immediately. Exhaustive sweep of all 64 opcodes checks the three invariants in every cycle.
